if_mem_arbiter: RTL and testbench
=================================

// Module: if_mem_arbiter
// PURPOSE
//  Shares one single-ported instruction/data memory between the IF stage and the MEM stage.
//  - Data accesses have priority over instruction fetches.
//  - Drives the freeze/flush controls of the IF stage pipeline register.
//  - Discards in-flight fetches that a taken branch makes stale.
//  - Sits between the PC/IF register and the memory interface, beside the hazard unit.
// PARAMETERS
//  ADDR_W   32  byte address width
//  DATA_W   32  instruction/data word width
//  TIMEOUT  15  max cycles waiting on mem_ready before abort; range 1..255
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       asynchronous, active-high reset
//  fetch_addr   in   ADDR_W  PC of next instruction; sampled on entry to FETCH
//  fetch_instr  out  DATA_W  fetched instruction, held until next delivery
//  fetch_valid  out  1       1-cycle pulse: fetch_instr is new and usable
//  data_req     in   1       MEM stage access request; held high until data_done
//  data_we      in   1       1 = store, 0 = load
//  data_addr    in   ADDR_W  load/store address; sampled on entry to DATA
//  data_wdata   in   DATA_W  store data; sampled on entry to DATA
//  data_rdata   out  DATA_W  load result, valid while data_done=1
//  data_done    out  1       1-cycle pulse: data access finished
//  br_taken     in   1       EX resolved a taken branch this cycle
//  mem_req      out  1       memory access strobe; registered
//  mem_we       out  1       memory write enable; registered
//  mem_addr     out  ADDR_W  memory address; registered
//  mem_wdata    out  DATA_W  memory write data; registered
//  mem_rdata    in   DATA_W  memory read data, valid with mem_ready
//  mem_ready    in   1       memory completes the access this cycle
//  freeze_if    out  1       hold PC and IF register
//  freeze_pipe  out  1       hold ID/EX/MEM registers
//  flush_if     out  1       clear IF register
//  err          out  1       sticky timeout flag
// BEHAVIOUR
//  Reset: state IDLE; all registered outputs and the discard flag = 0.
//   mem_req falls immediately on rst, even mid-access.
//  FSM, states IDLE / FETCH / DATA:
//   IDLE  -> DATA if data_req, else FETCH.
//         On entry, latch address/wdata/we into mem_*; set mem_req=1.
//   FETCH -> IDLE on mem_ready. mem_req=0 in the same edge.
//         fetch_instr<=mem_rdata. fetch_valid=1 next cycle unless discard, or br_taken in that cycle.
//   DATA  -> IDLE on mem_ready.
//         data_rdata<=mem_rdata for loads (stores leave it unchanged); data_done=1 next cycle.
//  No abort of an in-flight fetch. A data_req arriving during FETCH waits for mem_ready.
//  Latency (mem_ready on 1st request cycle) = 3 clk per access: IDLE, FETCH/DATA, pulse cycle in IDLE.
//   The pulse cycle overlaps the next IDLE decision.
//  freeze_if   = ~fetch_valid (combinational). PC advances only on delivered instructions.
//  freeze_pipe = data_req & ~data_done (combinational).
//  flush_if    = br_taken (combinational). Also sets discard when state==FETCH.
//   Discard clears when that fetch completes, with no fetch_valid pulse.
//   br_taken in IDLE or DATA does not set discard; the next FETCH samples the new fetch_addr.
//  Timeout: wait counter clears on FETCH/DATA entry and increments each cycle without mem_ready.
//   When it reaches TIMEOUT, set err (sticky until rst), drop mem_req, go IDLE.
//   In DATA: data_done pulses with data_rdata=0, to release the pipe.
//   In FETCH: no fetch_valid.
//  mem_ready is ignored in IDLE.
// STRUCTURE
//  Package if_mem_pkg: state enum (IDLE=2'd0, FETCH=2'd1, DATA=2'd2); TIMEOUT width constant 8.
//  Sub-module mem_wait_counter: 8-bit counter with clear/enable inputs and timeout output.
//   It takes the same clk/rst.
//  Everything else (FSM, output registers, discard flag) stays in this module.
// TESTING
//  1 Fetch only: memory model with mem_ready 1 cycle after mem_req, fetch_addr=0x40.
//    -> mem_addr=0x40; fetch_valid pulse carries mem_rdata; freeze_if low only in that cycle.
//  2 Priority: data_req (load @0x100) and FETCH entry decision in the same cycle.
//    -> DATA first; data_done with data_rdata; freeze_pipe high until data_done; then FETCH.
//  3 Stale fetch: br_taken during FETCH (mem_ready 3 cycles later).
//    -> flush_if pulse; no fetch_valid; next FETCH uses the new fetch_addr=0x200.
//  4 Store: data_we=1, data_addr=0x8, data_wdata=0xDEADBEEF.
//    -> mem_we=1 with matching addr/data; data_done pulse; data_rdata unchanged.
//  5 Timeout: mem_ready held 0.
//    -> after 15 waiting cycles: err=1, mem_req=0, state IDLE; err stays 1 until rst.
//  6 Reset mid-DATA access: assert rst asynchronously.
//    -> mem_req, data_done, fetch_valid, err = 0 before the next clk edge; FSM restarts in IDLE.

Source files
------------

// File: rtl/if_mem_pkg.sv
// if_mem_pkg: state encoding and counter width shared by the IF/MEM memory arbiter.
package if_mem_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DATA = 2'd2} state_e;
    localparam int CNT_W = 8;
endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: counts cycles spent waiting on mem_ready and flags the abort cycle.
module mem_wait_counter
    import if_mem_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    // Fires on the TIMEOUT-th waiting cycle so the FSM aborts on that edge.
    assign timeout = en && (cnt == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/if_mem_arbiter.sv
// if_mem_arbiter: shares one single-ported memory between IF fetches and MEM data accesses,
// data first, and drives the IF freeze/flush controls.
module if_mem_arbiter
    import if_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              fetch_valid,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_done,
    input  logic              br_taken,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              freeze_if,
    output logic              freeze_pipe,
    output logic              flush_if,
    output logic              err
);
    state_e state, state_nx;
    logic discard, busy, wait_en, ready, tmo, fin, go_data;

    assign busy    = state != IDLE;
    assign wait_en = busy & ~mem_ready;
    assign ready   = busy & mem_ready;
    assign fin     = ready | tmo;
    // data_req is still high during the data_done cycle; don't relaunch the same access.
    assign go_data = data_req & ~data_done;

    mem_wait_counter #(.TIMEOUT(TIMEOUT)) u_wait (
        .clk     (clk),
        .rst     (rst),
        .clr     (~busy),
        .en      (wait_en),
        .timeout (tmo)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? (go_data ? DATA : FETCH) : (fin ? IDLE : state);
    end

    always_comb begin
        freeze_if   = ~fetch_valid;
        freeze_pipe = data_req & ~data_done;
        flush_if    = br_taken;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            fetch_instr <= '0;
            fetch_valid <= 1'b0;
            data_rdata  <= '0;
            data_done   <= 1'b0;
            err         <= 1'b0;
            discard     <= 1'b0;
        end else begin
            mem_req <= (state == IDLE) | (mem_req & ~fin);
            if (state == IDLE) begin
                mem_we    <= go_data & data_we;
                mem_addr  <= go_data ? data_addr : fetch_addr;
                mem_wdata <= go_data ? data_wdata : '0;
            end else if (fin) mem_we <= 1'b0;
            fetch_valid <= (state == FETCH) & ready & ~discard & ~br_taken;
            if ((state == FETCH) & ready) fetch_instr <= mem_rdata;
            data_done <= (state == DATA) & fin;
            // A timed-out access returns zero so the stalled pipe can move on.
            if ((state == DATA) & fin & (tmo | ~mem_we)) data_rdata <= tmo ? '0 : mem_rdata;
            err     <= err | tmo;
            discard <= (state == FETCH) & ~fin & (discard | br_taken);
        end
endmodule

// File: tb/tb_if_mem_arbiter.sv
// tb_if_mem_arbiter: directed scenarios with a queue-based scoreboard for data results
// and a reference fetch word checked on every fetch_valid pulse.
module tb_if_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] fetch_addr = '0, data_addr = '0, data_wdata = '0;
    logic        data_req = 1'b0, data_we = 1'b0, br_taken = 1'b0;
    logic [31:0] fetch_instr, data_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        fetch_valid, data_done, mem_req, mem_we, mem_ready;
    logic        freeze_if, freeze_pipe, flush_if, err;

    always #5 clk = ~clk;

    if_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_addr  (fetch_addr),
        .fetch_instr (fetch_instr),
        .fetch_valid (fetch_valid),
        .data_req    (data_req),
        .data_we     (data_we),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_rdata  (data_rdata),
        .data_done   (data_done),
        .br_taken    (br_taken),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .freeze_if   (freeze_if),
        .freeze_pipe (freeze_pipe),
        .flush_if    (flush_if),
        .err         (err)
    );

    // Memory model: word i reads 0xA50000ii until written; ready after lat waiting cycles.
    int          lat = 0, wcnt = 0;
    bit          hang = 1'b0, wr_ok = 1'b0;
    logic [7:0]  wr_idx = '0;
    logic [31:0] wr_word = '0;
    assign mem_ready = mem_req && !hang && (wcnt == lat);
    assign mem_rdata = (wr_ok && mem_addr[9:2] == wr_idx) ? wr_word : (32'hA500_0000 | {24'd0, mem_addr[9:2]});
    always @(posedge clk) begin
        wcnt <= (!mem_req || mem_ready) ? 0 : wcnt + 1;
        if (mem_req && mem_ready && mem_we) begin
            wr_ok   <= 1'b1;
            wr_idx  <= mem_addr[9:2];
            wr_word <= mem_wdata;
        end
    end

    int          checks = 0, errors = 0, n_fetch = 0;
    logic [31:0] exp_instr = '0;
    bit          no_fetch = 1'b0;
    logic [31:0] data_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (fetch_valid) begin
            n_fetch++;
            chk("fetch_during_timeout", {63'd0, no_fetch}, 64'd0);
            if (!no_fetch) chk("fetch_instr", fetch_instr, exp_instr);
        end
        if (data_done) begin
            chk("data_done_expected", {63'd0, data_q.size() != 0}, 64'd1);
            if (data_q.size() != 0) chk("data_rdata", data_rdata, data_q.pop_front());
        end
    end

    function automatic logic sig(input int w);
        return w == 0 ? fetch_valid : w == 1 ? data_done : w == 2 ? mem_req : !mem_req;
    endfunction

    task automatic wait_for(input int which, input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sig(which) && n < 60);
        chk(nm, {63'd0, sig(which)}, 64'd1);
    endtask

    task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] ex, input string nm);
        wait_for(0, {nm, "_idle"});
        data_req = 1'b1; data_we = we; data_addr = a; data_wdata = wd;
        data_q.push_back(ex);
        @(negedge clk);
        chk({nm, "_mem_addr"}, mem_addr, a);
        chk({nm, "_mem_we"}, mem_we, we);
        if (we) chk({nm, "_mem_wdata"}, mem_wdata, wd);
        chk({nm, "_freeze_pipe_hi"}, freeze_pipe, 1);
        wait_for(1, {nm, "_done"});
        chk({nm, "_freeze_pipe_lo"}, freeze_pipe, 0);
        @(negedge clk);
        chk({nm, "_then_fetch"}, {mem_req, mem_we}, 2'b10);
        data_req = 1'b0; data_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] fv_pat, fz_pat;
        fetch_addr = 32'h40;
        exp_instr  = 32'hA500_0010;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_fetch_valid", fetch_valid, 0);
        chk("rst_data_done", data_done, 0);
        chk("rst_err", err, 0);
        chk("rst_freeze_if", freeze_if, 1);
        chk("rst_mem_addr", mem_addr, 0);
        rst = 1'b0;
        // 1: back-to-back fetches from 0x40, one pulse every other cycle
        fv_pat = '0; fz_pat = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            fv_pat = {fv_pat[4:0], fetch_valid};
            fz_pat = {fz_pat[4:0], freeze_if};
            if (k == 1) begin
                chk("t1_mem_addr", mem_addr, 32'h40);
                chk("t1_mem_req", {mem_req, mem_we}, 2'b10);
            end
        end
        chk("t1_fetch_valid_pattern", fv_pat, 6'b010101);
        chk("t1_freeze_if_pattern", fz_pat, 6'b101010);
        // 2: load wins the IDLE decision
        do_data(1'b0, 32'h100, 32'h0, 32'hA500_0040, "t2_load");
        // 3: taken branch during a slow fetch discards it
        wait_for(0, "t3_idle");
        lat = 3;
        @(negedge clk);
        br_taken = 1'b1; fetch_addr = 32'h200; exp_instr = 32'hA500_0080;
        #1 chk("t3_flush_if", flush_if, 1);
        @(negedge clk);
        br_taken = 1'b0;
        #1 chk("t3_flush_if_lo", flush_if, 0);
        wait_for(3, "t3_stale_done");
        @(negedge clk);
        chk("t3_new_addr", mem_addr, 32'h200);
        chk("t3_new_req", mem_req, 1);
        wait_for(0, "t3_new_fetch");
        lat = 0;
        // 4: store leaves data_rdata alone; read it back
        do_data(1'b1, 32'h8, 32'hDEAD_BEEF, 32'hA500_0040, "t4_store");
        do_data(1'b0, 32'h8, 32'h0, 32'hDEAD_BEEF, "t4_readback");
        // 5: fetch timeout, then data timeout from the same stuck memory
        wait_for(0, "t5_idle");
        hang = 1'b1;
        @(negedge clk);
        no_fetch = 1'b1;
        repeat (14) @(negedge clk);
        chk("t5_err_before", err, 0);
        chk("t5_req_before", mem_req, 1);
        @(negedge clk);
        chk("t5_err_set", err, 1);
        chk("t5_req_dropped", mem_req, 0);
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h100;
        data_q.push_back(32'h0);
        @(negedge clk);
        chk("t5_data_addr", mem_addr, 32'h100);
        wait_for(1, "t5_data_timeout_done");
        hang = 1'b0; no_fetch = 1'b0;
        @(negedge clk);
        data_req = 1'b0;
        wait_for(0, "t5_fetch_resumes");
        chk("t5_err_sticky", err, 1);
        // 6: asynchronous reset in the middle of a data access
        wait_for(0, "t6_idle");
        lat = 3;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h100;
        @(negedge clk);
        chk("t6_in_data", {mem_req, mem_addr}, {1'b1, 32'h100});
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_mem_req", mem_req, 0);
        chk("t6_rst_data_done", data_done, 0);
        chk("t6_rst_fetch_valid", fetch_valid, 0);
        chk("t6_rst_err", err, 0);
        data_req = 1'b0;
        lat = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_restart_fetch", {mem_req, mem_we}, 2'b10);
        chk("t6_restart_addr", mem_addr, 32'h200);
        wait_for(0, "t6_fetch_after_rst");
        chk("scoreboard_empty", data_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
